// File: rtl/pwm_pkg.sv
// Shared encodings and sizing helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  function automatic int pwm_max(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int pwm_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: emits a one-clock tick every prescale+1 enabled clocks.
module pwm_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pcnt;

  // >= rather than == so that lowering prescale mid-count still ticks next cycle
  assign tick = enable && (pcnt >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter, per-channel
// double-buffered duty, edge/center alignment and per-channel polarity.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int R     = 8,
  parameter  int PRE_W = 4,
  localparam int IDX_W = pwm_idx_w(CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic             mode,
  input  logic             duty_wr,
  input  logic [IDX_W-1:0] duty_ch,
  input  logic [R:0]       duty_data,
  input  logic [CH-1:0]    polarity,
  output logic [CH-1:0]    pwm_out,
  output logic             period_tick
);

  localparam logic [R-1:0] CNT_MAX = R'(pwm_max(R));

  logic            tick;
  logic [R-1:0]    cnt;
  pwm_dir_e        dir;
  pwm_mode_e       active_mode;
  logic [R:0]      pending_duty [CH];
  logic [R:0]      active_duty  [CH];
  logic            boundary;
  logic            bnd_q;
  logic [CH-1:0]   raw;

  pwm_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .prescale (prescale),
    .tick     (tick)
  );

  // The tick that reloads cnt with 0 starts a new period
  assign boundary = tick && ((active_mode == PWM_EDGE) ? (cnt == CNT_MAX)
                                                       : (dir == DIR_DOWN && cnt == R'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      active_mode <= PWM_EDGE;
    end else if (tick) begin
      if (boundary) begin
        cnt         <= '0;
        dir         <= DIR_UP;
        active_mode <= pwm_mode_e'(mode);
      end else if (active_mode == PWM_EDGE) begin
        cnt <= cnt + 1'b1;
      end else if (dir == DIR_UP) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_MAX - 1'b1) dir <= DIR_DOWN;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Boundary copy uses the pre-edge pending value, so a same-cycle write lands one period later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        pending_duty[i] <= '0;
        active_duty[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (duty_wr && duty_ch == IDX_W'(i)) pending_duty[i] <= duty_data;
        if (boundary) active_duty[i] <= pending_duty[i];
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cmp
    assign raw[g] = ({1'b0, cnt} < active_duty[g]);
  end

  // period_tick lags the boundary by one extra clock to line up with pwm_out showing cnt = 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnd_q       <= 1'b0;
      period_tick <= 1'b0;
      pwm_out     <= '0;
    end else begin
      bnd_q       <= boundary;
      period_tick <= bnd_q && enable;
      pwm_out     <= enable ? (raw ^ polarity) : polarity;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel with CH=4, R=4, PRE_W=4.
module tb_pwm_multi_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] prescale;
  logic       mode;
  logic       duty_wr;
  logic [1:0] duty_ch;
  logic [4:0] duty_data;
  logic [3:0] polarity;
  logic [3:0] pwm_out;
  logic       period_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int per_len;
  int hi_cnt [4];

  typedef struct {
    logic            mode;
    logic [3:0]      pre;
    logic [3:0][4:0] duty;
    logic [3:0]      pol;
    int              per;
    logic [3:0][7:0] hi;
  } vec_t;

  vec_t vec [5];

  pwm_multi_channel #(.CH(4), .R(4), .PRE_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .prescale    (prescale),
    .mode        (mode),
    .duty_wr     (duty_wr),
    .duty_ch     (duty_ch),
    .duty_data   (duty_data),
    .polarity    (polarity),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_duty(input int ch, input logic [4:0] d);
    duty_ch   = 2'(ch);
    duty_data = d;
    duty_wr   = 1'b1;
    @(negedge clk);
    duty_wr   = 1'b0;
  endtask

  // Returns at a negedge where period_tick is high
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 200);
    if (!period_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no period_tick, expected one within 200 clocks", name);
    end
  endtask

  // Starts on a period_tick negedge, counts one full period up to the next tick
  task automatic measure(input string name);
    bit ok;
    ok      = 1'b0;
    per_len = 0;
    for (int c = 0; c < 4; c++) hi_cnt[c] = 0;
    for (int k = 0; k < 200; k++) begin
      for (int c = 0; c < 4; c++) if (pwm_out[c]) hi_cnt[c]++;
      per_len++;
      @(negedge clk);
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no closing period_tick, expected one within 200 clocks", name);
    end
  endtask

  function automatic vec_t mk(input logic m, input logic [3:0] p, input logic [3:0][4:0] d,
                              input logic [3:0] pol, input int per, input logic [3:0][7:0] hi);
    vec_t v;
    v.mode = m;
    v.pre  = p;
    v.duty = d;
    v.pol  = pol;
    v.per  = per;
    v.hi   = hi;
    return v;
  endfunction

  initial begin
    int n;
    int hi1;
    logic [3:0] seen;

    // duty / hi packed as {ch3, ch2, ch1, ch0}
    vec[0] = mk(1'b0, 4'd0, {5'd16, 5'd0,  5'd8,  5'd4}, 4'b0000, 16, {8'd16, 8'd0,  8'd8, 8'd4});
    vec[1] = mk(1'b1, 4'd0, {5'd15, 5'd16, 5'd0,  5'd5}, 4'b0000, 30, {8'd29, 8'd30, 8'd0, 8'd9});
    vec[2] = mk(1'b0, 4'd2, {5'd0,  5'd31, 5'd1,  5'd8}, 4'b0000, 48, {8'd0,  8'd48, 8'd3, 8'd24});
    vec[3] = mk(1'b0, 4'd0, {5'd16, 5'd0,  5'd8,  5'd4}, 4'b0101, 16, {8'd16, 8'd16, 8'd8, 8'd12});
    vec[4] = mk(1'b1, 4'd1, {5'd8,  5'd2,  5'd15, 5'd1}, 4'b1010, 60, {8'd30, 8'd6,  8'd2, 8'd2});

    rst_n = 1'b0; enable = 1'b0; prescale = 4'd0; mode = 1'b0;
    duty_wr = 1'b0; duty_ch = 2'd0; duty_data = 5'd0; polarity = 4'b0000;

    #12;
    check("reset pwm_out", pwm_out, 0);
    check("reset period_tick", period_tick, 0);

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    seen   = 4'b0000;
    repeat (5) begin
      @(negedge clk);
      seen |= pwm_out;
    end
    check("post-reset outputs idle", seen, 0);

    for (int v = 0; v < 5; v++) begin
      mode     = vec[v].mode;
      prescale = vec[v].pre;
      polarity = vec[v].pol;
      for (int c = 0; c < 4; c++) write_duty(c, vec[v].duty[c]);
      wait_tick($sformatf("v%0d sync1", v));
      wait_tick($sformatf("v%0d sync2", v));
      measure($sformatf("v%0d measure", v));
      check($sformatf("v%0d period", v), per_len, vec[v].per);
      for (int c = 0; c < 4; c++)
        check($sformatf("v%0d ch%0d high", v, c), hi_cnt[c], int'(vec[v].hi[c]));
    end

    // Shadow update: mid-period write, then a write on the exact boundary edge
    mode = 1'b0; prescale = 4'd0; polarity = 4'b0000;
    write_duty(1, 5'd5);
    wait_tick("shadow sync1");
    wait_tick("shadow sync2");
    hi1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (pwm_out[1]) hi1++;
      duty_ch   = 2'd1;
      duty_wr   = (k == 0) || (k == 14);
      duty_data = (k == 0) ? 5'd12 : 5'd3;
      @(negedge clk);
    end
    duty_wr = 1'b0;
    check("shadow boundary tick", period_tick, 1);
    check("shadow current period ch1", hi1, 5);
    measure("shadow next");
    check("shadow next period ch1", hi_cnt[1], 12);
    measure("shadow after");
    check("shadow period after ch1", hi_cnt[1], 3);

    // Polarity and enable: inactive level while stopped, resume from held cnt
    polarity = 4'b0101;
    wait_tick("enable sync");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("disabled clk%0d out+tick", k), {period_tick, pwm_out}, 5'b00101);
    end
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 100);
    check("resume clocks to period_tick", n, 13);

    // Async reset mid-period in center mode
    polarity = 4'b0000;
    mode     = 1'b1;
    write_duty(3, 5'd16);
    wait_tick("reset sync1");
    wait_tick("reset sync2");
    repeat (7) @(negedge clk);
    check("pre-reset ch3 high", pwm_out[3], 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset pwm_out", pwm_out, 0);
    check("async reset period_tick", period_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
    seen  = 4'b0000;
    do begin
      @(negedge clk);
      n++;
      seen |= pwm_out;
    end while (!period_tick && n < 100);
    check("post-reset first period is edge length", n, 17);
    check("post-reset outputs idle to boundary", seen, 0);
    measure("post-reset period");
    check("post-reset center period", per_len, 30);
    check("post-reset ch3 still low", hi_cnt[3], 0);
    write_duty(3, 5'd16);
    wait_tick("rewrite sync1");
    wait_tick("rewrite sync2");
    measure("rewrite period");
    check("rewrite period", per_len, 30);
    check("rewrite ch3 high", hi_cnt[3], 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
